// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters with region FSMs. Every output is
// registered from the current counter/state, so the pins lag the counters by one enabled cycle.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        en,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic        pre_de,
    output logic [11:0] px_x,
    output logic [11:0] px_y,
    output logic        frame_start,
    output logic        line_start
);

    localparam logic [11:0] H_ACT_LAST  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] H_FP_LAST   = 12'(H_ACTIVE + H_FP - 1);
    localparam logic [11:0] H_SYNC_LAST = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] H_LAST      = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT_LAST  = 12'(V_ACTIVE - 1);
    localparam logic [11:0] V_FP_LAST   = 12'(V_ACTIVE + V_FP - 1);
    localparam logic [11:0] V_SYNC_LAST = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] V_LAST      = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic        SYNC_ON     = (SYNC_POL != 0);

    typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
    typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

    h_state_t    h_state_reg, h_state_next;
    v_state_t    v_state_reg, v_state_next;
    logic [11:0] h_cnt_reg, h_cnt_next;
    logic [11:0] v_cnt_reg, v_cnt_next;
    logic        h_wrap;
    logic        de_cur;

    assign h_wrap = (h_cnt_reg == H_LAST);
    assign de_cur = (h_state_reg == HS_ACT) && (v_state_reg == VS_ACT);

    always_comb begin
        h_cnt_next   = h_wrap ? 12'd0 : h_cnt_reg + 12'd1;
        v_cnt_next   = v_cnt_reg;
        h_state_next = h_state_reg;
        v_state_next = v_state_reg;

        case (h_state_reg)
            HS_ACT:  if (h_cnt_reg == H_ACT_LAST)  h_state_next = HS_FP;
            HS_FP:   if (h_cnt_reg == H_FP_LAST)   h_state_next = HS_SYNC;
            HS_SYNC: if (h_cnt_reg == H_SYNC_LAST) h_state_next = HS_BP;
            default: if (h_wrap)                   h_state_next = HS_ACT;
        endcase

        // The vertical side moves only on the last pixel of a line.
        if (h_wrap) begin
            v_cnt_next = (v_cnt_reg == V_LAST) ? 12'd0 : v_cnt_reg + 12'd1;
            case (v_state_reg)
                VS_ACT:  if (v_cnt_reg == V_ACT_LAST)  v_state_next = VS_FP;
                VS_FP:   if (v_cnt_reg == V_FP_LAST)   v_state_next = VS_SYNC;
                VS_SYNC: if (v_cnt_reg == V_SYNC_LAST) v_state_next = VS_BP;
                default: if (v_cnt_reg == V_LAST)      v_state_next = VS_ACT;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_reg   <= 12'd0;
            v_cnt_reg   <= 12'd0;
            h_state_reg <= HS_ACT;
            v_state_reg <= VS_ACT;
            hs          <= ~SYNC_ON;
            vs          <= ~SYNC_ON;
            de          <= 1'b0;
            pre_de      <= 1'b0;
            px_x        <= 12'd0;
            px_y        <= 12'd0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (en) begin
            h_cnt_reg   <= h_cnt_next;
            v_cnt_reg   <= v_cnt_next;
            h_state_reg <= h_state_next;
            v_state_reg <= v_state_next;
            hs          <= (h_state_reg == HS_SYNC) ? SYNC_ON : ~SYNC_ON;
            vs          <= (v_state_reg == VS_SYNC) ? SYNC_ON : ~SYNC_ON;
            de          <= de_cur;
            // Decoding the next state makes the read request lead de by one cycle.
            pre_de      <= (h_state_next == HS_ACT) && (v_state_next == VS_ACT);
            px_x        <= de_cur ? h_cnt_reg : 12'd0;
            px_y        <= de_cur ? v_cnt_reg : 12'd0;
            frame_start <= de_cur && (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
            line_start  <= de_cur && (h_cnt_reg == 12'd0);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a small 15x8 raster (H 8/2/3/2, V 4/1/2/1).
module tb_video_timing_gen;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic        hs, vs, de, pre_de, frame_start, line_start;
    logic [11:0] px_x, px_y;

    int tests  = 0;
    int failed = 0;
    int edge_n = 0;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .en(en),
        .hs(hs), .vs(vs), .de(de), .pre_de(pre_de),
        .px_x(px_x), .px_y(px_y),
        .frame_start(frame_start), .line_start(line_start)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          k;
        logic        de, hs, vs, pre_de, fs, ls;
        logic [11:0] x, y;
    } vec_t;

    vec_t vecs[15];

    logic de_h[0:241];
    logic pre_h[0:241];
    logic hs_h[0:241];
    logic vs_h[0:241];
    logic fs_h[0:241];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
        if (en) edge_n++;
    endtask

    function automatic vec_t mk(int k, logic d, logic h, logic v, logic p,
                                logic f, logic l, int x, int y);
        vec_t r;
        r.k = k; r.de = d; r.hs = h; r.vs = v; r.pre_de = p;
        r.fs = f; r.ls = l; r.x = 12'(x); r.y = 12'(y);
        return r;
    endfunction

    int cnt, first, guard, exp_x;

    initial begin
        // Edge k shows the counter state from linear index n = k-1 (h = n%15, v = n/15 % 8).
        //           k    de hs vs pre fs ls  x  y
        vecs[0]  = mk(1,   1, 1, 1, 1, 1, 1, 0, 0);
        vecs[1]  = mk(8,   1, 1, 1, 0, 0, 0, 7, 0);
        vecs[2]  = mk(9,   0, 1, 1, 0, 0, 0, 0, 0);
        vecs[3]  = mk(11,  0, 0, 1, 0, 0, 0, 0, 0);
        vecs[4]  = mk(13,  0, 0, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(14,  0, 1, 1, 0, 0, 0, 0, 0);
        vecs[6]  = mk(15,  0, 1, 1, 1, 0, 0, 0, 0);
        vecs[7]  = mk(16,  1, 1, 1, 1, 0, 1, 0, 1);
        vecs[8]  = mk(60,  0, 1, 1, 0, 0, 0, 0, 0);
        vecs[9]  = mk(61,  0, 1, 1, 0, 0, 0, 0, 0);
        vecs[10] = mk(76,  0, 1, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(105, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(106, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[13] = mk(120, 0, 1, 1, 1, 0, 0, 0, 0);
        vecs[14] = mk(121, 1, 1, 1, 1, 1, 1, 0, 0);

        // Reset state
        repeat (3) @(negedge clk_in);
        chk("reset_hs", hs, 1'b1);
        chk("reset_vs", vs, 1'b1);
        chk("reset_de", de, 1'b0);
        chk("reset_pre_de", pre_de, 1'b0);
        chk("reset_px", {px_x, px_y}, 24'd0);
        chk("reset_pulses", {frame_start, line_start}, 2'b00);

        rst_n = 1'b1;
        en    = 1'b1;
        for (int t = 1; t <= 240; t++) begin
            step();
            de_h[t] = de; pre_h[t] = pre_de; hs_h[t] = hs; vs_h[t] = vs; fs_h[t] = frame_start;
            for (int i = 0; i < 15; i++) begin
                if (vecs[i].k == edge_n) begin
                    chk($sformatf("v%0d_de", vecs[i].k), de, vecs[i].de);
                    chk($sformatf("v%0d_hs", vecs[i].k), hs, vecs[i].hs);
                    chk($sformatf("v%0d_vs", vecs[i].k), vs, vecs[i].vs);
                    chk($sformatf("v%0d_pre_de", vecs[i].k), pre_de, vecs[i].pre_de);
                    chk($sformatf("v%0d_fs", vecs[i].k), frame_start, vecs[i].fs);
                    chk($sformatf("v%0d_ls", vecs[i].k), line_start, vecs[i].ls);
                    chk($sformatf("v%0d_px", vecs[i].k), {px_x, px_y}, {vecs[i].x, vecs[i].y});
                end
            end
        end

        cnt = 0;
        for (int t = 1; t < 240; t++) if (pre_h[t] !== de_h[t+1]) cnt++;
        chk("pre_de_leads_de", cnt, 0);
        for (int f = 0; f < 2; f++) begin
            cnt = 0;
            for (int t = 1 + f*120; t <= 120 + f*120; t++) if (de_h[t]) cnt++;
            chk($sformatf("de_count_frame%0d", f), cnt, 32);
        end
        cnt = 0; first = 0;
        for (int t = 1; t <= 15; t++) if (!hs_h[t]) begin cnt++; if (first == 0) first = t; end
        chk("hs_low_width", cnt, 3);
        chk("hs_low_offset", first - 1, 10);
        cnt = 0; first = 0;
        for (int t = 1; t <= 120; t++) if (!vs_h[t]) begin cnt++; if (first == 0) first = t; end
        chk("vs_low_width", cnt, 30);
        chk("vs_low_offset", first - 1, 75);
        cnt = 0; first = 0;
        for (int t = 1; t <= 240; t++) if (fs_h[t]) begin cnt++; if (first == 0) first = t; end
        chk("frame_start_count", cnt, 2);
        chk("frame_start_period", fs_h[121], 1'b1);

        // Freeze mid-line at px_x = 3, then check the line still carries 0..7 once each
        guard = 0;
        while (!(de && px_x == 12'd3) && guard < 200) begin step(); guard++; end
        chk("reach_px3", guard < 200, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("frozen_px", {de, px_x}, {1'b1, 12'd3});
        end
        en = 1'b1;
        exp_x = 4;
        step();
        while (de && exp_x < 12) begin
            chk($sformatf("resume_px%0d", exp_x), px_x, 12'(exp_x));
            exp_x++;
            step();
        end
        chk("line_pixel_total", exp_x, 8);

        // Pulse held, not repeated, while en is low
        guard = 0;
        while (!line_start && guard < 200) begin step(); guard++; end
        chk("reach_line_start", guard < 200, 1'b1);
        en = 1'b0;
        repeat (3) step();
        chk("ls_held", {line_start, px_x}, {1'b1, 12'd0});
        en = 1'b1;
        step();
        chk("ls_single", {line_start, px_x}, {1'b0, 12'd1});

        // Asynchronous reset at px = (5,2)
        guard = 0;
        while (!(de && px_x == 12'd5 && px_y == 12'd2) && guard < 300) begin step(); guard++; end
        chk("reach_5_2", guard < 300, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", {hs, vs, de}, 3'b110);
        chk("async_rst_px", {px_x, px_y}, 24'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("restart_px", {de, px_x, px_y}, {1'b1, 24'd0});
        chk("restart_fs", frame_start, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
